// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing (hsync, vsync, de, x/y, line/frame pulses) from per-axis phase FSMs.
// Define VGA_TEXT_CELL_EN to add cellCol/cellRow/glyphX/glyphY text-cell outputs.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP = 33,
    parameter int HSYNC_POL = 0,
    parameter int VSYNC_POL = 0,
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int XW = $clog2(H_TOTAL),
    localparam int YW = $clog2(V_TOTAL),
    localparam int CW = (H_ACTIVE / 8 > 1) ? $clog2(H_ACTIVE / 8) : 1,
    localparam int RW = (V_ACTIVE / 16 > 1) ? $clog2(V_ACTIVE / 16) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pixEn,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          lineStart,
    output logic          frameStart
`ifdef VGA_TEXT_CELL_EN
    ,
    output logic [CW-1:0] cellCol,
    output logic [RW-1:0] cellRow,
    output logic [2:0]    glyphX,
    output logic [3:0]    glyphY
`endif
);
    typedef enum logic [1:0] {ACT, FP, SYNC, BP} phase_t;

    localparam logic HP = 1'(HSYNC_POL);
    localparam logic VP = 1'(VSYNC_POL);

    function automatic int hLen(phase_t s);
        return s == ACT ? H_ACTIVE : s == FP ? H_FP : s == SYNC ? H_SYNC : H_BP;
    endfunction

    function automatic int vLen(phase_t s);
        return s == ACT ? V_ACTIVE : s == FP ? V_FP : s == SYNC ? V_SYNC : V_BP;
    endfunction

    // Phase state and counters describe the position presented on the next pixEn.
    phase_t hState, vState;
    logic [XW-1:0] hCnt, nx;
    logic [YW-1:0] vCnt, ny;
    logic hEnd, vEnd, hWrap, vWrap;
`ifdef VGA_TEXT_CELL_EN
    logic [CW-1:0] nCol;
    logic [RW-1:0] nRow;
    logic [2:0] nGx;
    logic [3:0] nGy;
`endif

    always_comb begin
        hEnd = hCnt == XW'(hLen(hState) - 1);
        vEnd = vCnt == YW'(vLen(vState) - 1);
        hWrap = hEnd && hState == BP;
        vWrap = vEnd && vState == BP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hState <= ACT;
            vState <= ACT;
            hCnt <= '0;
            vCnt <= '0;
            nx <= '0;
            ny <= '0;
            x <= '0;
            y <= '0;
            de <= 1'b0;
            hsync <= ~HP;
            vsync <= ~VP;
            lineStart <= 1'b0;
            frameStart <= 1'b0;
`ifdef VGA_TEXT_CELL_EN
            nCol <= '0;
            nRow <= '0;
            nGx <= '0;
            nGy <= '0;
            cellCol <= '0;
            cellRow <= '0;
            glyphX <= '0;
            glyphY <= '0;
`endif
        end else if (pixEn) begin
            x <= nx;
            y <= ny;
            de <= hState == ACT && vState == ACT;
            hsync <= hState == SYNC ? HP : ~HP;
            vsync <= vState == SYNC ? VP : ~VP;
            lineStart <= nx == '0;
            frameStart <= nx == '0 && ny == '0;
            hState <= hEnd ? phase_t'(hState + 2'd1) : hState;
            hCnt <= hEnd ? '0 : hCnt + 1'b1;
            nx <= hWrap ? '0 : nx + 1'b1;
            if (hWrap) begin
                vState <= vEnd ? phase_t'(vState + 2'd1) : vState;
                vCnt <= vEnd ? '0 : vCnt + 1'b1;
                ny <= vWrap ? '0 : ny + 1'b1;
            end
`ifdef VGA_TEXT_CELL_EN
            cellCol <= nCol;
            cellRow <= nRow;
            glyphX <= nGx;
            glyphY <= nGy;
            // Cell counters stop at the last active cell and hold through blanking.
            if (hWrap) begin
                nCol <= '0;
                nGx <= '0;
            end else if (hState == ACT && !hEnd) begin
                nGx <= nGx + 1'b1;
                nCol <= nGx == 3'd7 ? nCol + 1'b1 : nCol;
            end
            if (hWrap && vWrap) begin
                nRow <= '0;
                nGy <= '0;
            end else if (hWrap && vState == ACT && !vEnd) begin
                nGy <= nGy + 1'b1;
                nRow <= nGy == 4'd15 ? nRow + 1'b1 : nRow;
            end
`endif
        end else begin
            lineStart <= 1'b0;
            frameStart <= 1'b0;
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: checks a default-timing and a tiny-timing vga_sync_gen against a position-based model.
module tb_vga_sync_gen;
    logic clk = 1'b0;
    logic reset;
    logic pixEn;

    always #5 clk = ~clk;

    logic hsA, vsA, deA, lsA, fsA;
    logic [9:0] xA, yA;
    logic hsB, vsB, deB, lsB, fsB;
    logic [3:0] xB;
    logic [2:0] yB;
`ifdef VGA_TEXT_CELL_EN
    logic [6:0] ccA;
    logic [4:0] crA;
    logic [2:0] gxA, gxB;
    logic [3:0] gyA, gyB;
    logic [0:0] ccB, crB;
`endif

    vga_sync_gen dutA (
        .clk(clk), .reset(reset), .pixEn(pixEn), .hsync(hsA), .vsync(vsA), .de(deA),
        .x(xA), .y(yA), .lineStart(lsA), .frameStart(fsA)
`ifdef VGA_TEXT_CELL_EN
        , .cellCol(ccA), .cellRow(crA), .glyphX(gxA), .glyphY(gyA)
`endif
    );

    vga_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dutB (
        .clk(clk), .reset(reset), .pixEn(pixEn), .hsync(hsB), .vsync(vsB), .de(deB),
        .x(xB), .y(yB), .lineStart(lsB), .frameStart(fsB)
`ifdef VGA_TEXT_CELL_EN
        , .cellCol(ccB), .cellRow(crB), .glyphX(gxB), .glyphY(gyB)
`endif
    );

    int ox[2], oy[2];
    bit ohs[2], ovs[2], ode[2], ols[2], ofs[2];
    assign ox[0] = int'(xA);
    assign ox[1] = int'(xB);
    assign oy[0] = int'(yA);
    assign oy[1] = int'(yB);
    assign ohs[0] = hsA;
    assign ohs[1] = hsB;
    assign ovs[0] = vsA;
    assign ovs[1] = vsB;
    assign ode[0] = deA;
    assign ode[1] = deB;
    assign ols[0] = lsA;
    assign ols[1] = lsB;
    assign ofs[0] = fsA;
    assign ofs[1] = fsB;
`ifdef VGA_TEXT_CELL_EN
    int occ[2], ocr[2], ogx[2], ogy[2];
    assign occ[0] = int'(ccA);
    assign occ[1] = int'(ccB);
    assign ocr[0] = int'(crA);
    assign ocr[1] = int'(crB);
    assign ogx[0] = int'(gxA);
    assign ogx[1] = int'(gxB);
    assign ogy[0] = int'(gyA);
    assign ogy[1] = int'(gyB);
`endif

    // Timing of each instance: active, front porch, sync, back porch; both polarities active-low.
    int hp[2][4] = '{'{640, 16, 96, 48}, '{8, 2, 2, 2}};
    int vp[2][4] = '{'{480, 10, 2, 33}, '{4, 1, 1, 1}};

    int nx[2], ny[2], ex[2], ey[2];
    bit eLs[2], eFs[2], eDe[2], eHs[2], eVs[2];
    int nCmp = 0;
    int nBad = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        nCmp++;
        assert (obs === exp) else begin
            nBad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 2; i++) begin
            nx[i] = 0; ny[i] = 0; ex[i] = 0; ey[i] = 0;
            eLs[i] = 0; eFs[i] = 0; eDe[i] = 0; eHs[i] = 1; eVs[i] = 1;
        end
    endtask

    task automatic modelStep(input bit en);
        for (int i = 0; i < 2; i++) begin
            if (en) begin
                int hs0, vs0;
                hs0 = hp[i][0] + hp[i][1];
                vs0 = vp[i][0] + vp[i][1];
                ex[i] = nx[i];
                ey[i] = ny[i];
                eLs[i] = nx[i] == 0;
                eFs[i] = nx[i] == 0 && ny[i] == 0;
                eDe[i] = ex[i] < hp[i][0] && ey[i] < vp[i][0];
                eHs[i] = !(ex[i] >= hs0 && ex[i] < hs0 + hp[i][2]);
                eVs[i] = !(ey[i] >= vs0 && ey[i] < vs0 + vp[i][2]);
                nx[i]++;
                if (nx[i] == hp[i][0] + hp[i][1] + hp[i][2] + hp[i][3]) begin
                    nx[i] = 0;
                    ny[i]++;
                    if (ny[i] == vp[i][0] + vp[i][1] + vp[i][2] + vp[i][3]) ny[i] = 0;
                end
            end else begin
                eLs[i] = 0;
                eFs[i] = 0;
            end
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < 2; i++) begin
            string p;
            p = i == 0 ? "A" : "B";
            chk($sformatf("%s.x", p), ox[i], ex[i]);
            chk($sformatf("%s.y", p), oy[i], ey[i]);
            chk($sformatf("%s.de", p), ode[i], eDe[i]);
            chk($sformatf("%s.hsync", p), ohs[i], eHs[i]);
            chk($sformatf("%s.vsync", p), ovs[i], eVs[i]);
            chk($sformatf("%s.lineStart", p), ols[i], eLs[i]);
            chk($sformatf("%s.frameStart", p), ofs[i], eFs[i]);
`ifdef VGA_TEXT_CELL_EN
            begin
                int cx, cy;
                cx = ex[i] < hp[i][0] ? ex[i] : hp[i][0] - 1;
                cy = ey[i] < vp[i][0] ? ey[i] : vp[i][0] - 1;
                chk($sformatf("%s.cellCol", p), occ[i], cx / 8);
                chk($sformatf("%s.glyphX", p), ogx[i], cx % 8);
                chk($sformatf("%s.cellRow", p), ocr[i], cy / 16);
                chk($sformatf("%s.glyphY", p), ogy[i], cy % 16);
            end
`endif
        end
    endtask

    task automatic cyc(input bit en);
        pixEn = en;
        @(posedge clk);
        #1;
        modelStep(en);
        checkAll();
    endtask

    initial begin
        reset = 1'b1;
        pixEn = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        checkAll();
        cyc(1'b0);
        cyc(1'b1);
        repeat (2000) cyc(1'b1);
        repeat (4000) cyc(1'(($urandom % 2)));
        for (int k = 0; k < 1000; k++) cyc(1'(k % 2 == 0));
        // Asynchronous reset landing between clock edges.
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge clk);
        #1;
        checkAll();
        reset = 1'b0;
        cyc(1'b1);
        repeat (30000) cyc(1'b1);
        repeat (2000) cyc(1'(($urandom % 4) != 0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end
endmodule
